// File: rtl/norm_shift_if.sv
// norm_shift_if: request/result bundle between a normalizer client and norm_shift_unit.
// Signals: start, data[31:0] (and cnt_ones when NORM_CLO_EN is defined) from client;
//          busy, done, result[31:0], count[5:0], zero back from the unit.
// Modports: master (client side), slave (unit side).
interface norm_shift_if;
    logic        start;
    logic [31:0] data;
`ifdef NORM_CLO_EN
    logic        cnt_ones;
`endif
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [5:0]  count;
    logic        zero;
`ifdef NORM_CLO_EN
    modport master (output start, data, cnt_ones, input busy, done, result, count, zero);
    modport slave  (input start, data, cnt_ones, output busy, done, result, count, zero);
`else
    modport master (output start, data, input busy, done, result, count, zero);
    modport slave  (input start, data, output busy, done, result, count, zero);
`endif
endinterface

// File: rtl/norm_shift_unit.sv
// norm_shift_unit: multi-cycle left normalizer, shifts up to STEP bits per cycle until bit 31 is set.
// Ports: clk, rst_n (async active-low), bus (norm_shift_if.slave):
//   in  start, data[31:0] (+ cnt_ones with NORM_CLO_EN)
//   out busy (SHIFT), done (one-cycle pulse), result = data << count, count 0..32, zero
// Optional feature: define NORM_CLO_EN to add cnt_ones, selecting leading-ones counting.
module norm_shift_unit #(
    parameter int STEP = 4
) (
    input logic         clk,
    input logic         rst_n,
    norm_shift_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [5:0]  count_q, count_d;
    logic        zero_q, zero_d;
    logic        ones_q, ones_d;
    logic        ones_in;
    logic        all_same;
    logic [STEP-1:0] top;
    int          k;
    if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8) begin : g_bad_step
        $error("norm_shift_unit: STEP must be 1, 2, 4 or 8");
    end
`ifdef NORM_CLO_EN
    assign ones_in = bus.cnt_ones;
`else
    assign ones_in = 1'b0;
`endif
    // An operand made entirely of the counted bit value finishes without iterating.
    assign all_same = ones_in ? (&bus.data) : ~(|bus.data);
    // Inverting in ones mode lets a single leading-zero search serve both modes.
    assign top = work_q[31 -: STEP] ^ {STEP{ones_q}};
    always_comb begin
        k = STEP;
        for (int i = 0; i < STEP; i++)
            if (top[i]) k = STEP - 1 - i;
    end
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        zero_d  = zero_q;
        ones_d  = ones_q;
        if (bus.start && state_q != SHIFT) begin
            ones_d  = ones_in;
            zero_d  = all_same;
            work_d  = all_same ? 32'h0 : bus.data;
            count_d = all_same ? 6'd32 : 6'd0;
            state_d = all_same ? DONE : SHIFT;
        end else if (state_q == SHIFT) begin
            work_d  = work_q << k;
            count_d = count_q + 6'(k);
            state_d = (k < STEP) ? DONE : SHIFT;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 32'h0;
            count_q <= 6'd0;
            zero_q  <= 1'b0;
            ones_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            ones_q  <= ones_d;
        end
    end
    assign bus.busy   = (state_q == SHIFT);
    assign bus.done   = (state_q == DONE);
    assign bus.result = work_q;
    assign bus.count  = count_q;
    assign bus.zero   = zero_q;
endmodule
